// File: rtl/termbuffer_scroll.sv
`default_nettype none
// ============================================================================
// termbuffer_scroll: ROWS x COLS character grid with cursor, wrap and scroll,
// streaming ANSI full-screen redraws to a UART TX. Optional: TERMBUF_CURSOR_EN.
// Revision: 1.0
// ============================================================================
module termbuffer_scroll #(
  parameter int         COLS = 32,
  parameter int         ROWS = 8,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_v,
  output logic       o_in_rdy,
  output logic [7:0] o_byte,
  output logic       o_byte_v,
  input  logic       i_tx_done,
  output logic       o_busy
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]   ROWS_E    = (ROW_W+1)'(ROWS);
  localparam logic [AW-1:0]    CELL_LAST = AW'(CELLS - 1);
  localparam logic [AW-1:0]    COLS_A    = AW'(COLS);

  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r,
                                                input logic [ROW_W-1:0] t);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= ROWS_E) s = s - ROWS_E;
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] pr,
                                              input logic [COL_W-1:0] c);
    return AW'(pr) * COLS_A + AW'(c);
  endfunction

  // --------------------------------------------------------------------------
  // Writer: init fill, byte handling, bottom-line clear after scroll
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_CLR} wstate_t;

  wstate_t          wstate, wstate_n;
  logic [ROW_W-1:0] row, row_n, top, top_n, bottom_phys;
  logic [COL_W-1:0] col, col_n;
  logic [AW-1:0]    cnt, cnt_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [7:0]       wdata;
  logic             req;
  logic             accept, printable, line_feed;

  assign o_in_rdy    = (wstate == W_IDLE);
  assign accept      = i_byte_v && o_in_rdy;
  assign printable   = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
  assign bottom_phys = (top == '0) ? ROW_LAST : top - ROW_W'(1);

  always_comb begin
    wstate_n  = wstate;
    row_n     = row;
    col_n     = col;
    top_n     = top;
    cnt_n     = cnt;
    we        = 1'b0;
    waddr     = cnt;
    wdata     = FILL;
    req       = 1'b0;
    line_feed = 1'b0;
    case (wstate)
      W_INIT: begin
        we = 1'b1;
        if (cnt == CELL_LAST) begin
          cnt_n    = '0;
          wstate_n = W_IDLE;
          req      = 1'b1;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      W_IDLE: begin
        if (accept) begin
          if (printable) begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(row, top), col);
            wdata = i_byte;
            req   = 1'b1;
            if (col == COL_LAST) begin
              col_n     = '0;
              line_feed = 1'b1;
            end else begin
              col_n = col + COL_W'(1);
            end
          end else if (i_byte == 8'h0D) begin
            col_n = '0;
            req   = 1'b1;
          end else if (i_byte == 8'h0A) begin
            line_feed = 1'b1;
            req       = 1'b1;
          end else if (i_byte == 8'h08) begin
            if (col != '0) col_n = col - COL_W'(1);
            req = 1'b1;
          end
          if (line_feed) begin
            if (row != ROW_LAST) begin
              row_n = row + ROW_W'(1);
            end else begin
              // Scroll by moving the top pointer; the redraw is requested once
              // the recycled line has been cleared.
              top_n    = (top == ROW_LAST) ? '0 : top + ROW_W'(1);
              cnt_n    = '0;
              wstate_n = W_CLR;
              req      = 1'b0;
            end
          end
        end
      end
      W_CLR: begin
        we    = 1'b1;
        waddr = cell_addr(bottom_phys, cnt[COL_W-1:0]);
        if (cnt[COL_W-1:0] == COL_LAST) begin
          cnt_n    = '0;
          wstate_n = W_IDLE;
          req      = 1'b1;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      default: wstate_n = W_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate <= W_INIT;
      row    <= '0;
      col    <= '0;
      top    <= '0;
      cnt    <= '0;
    end else begin
      wstate <= wstate_n;
      row    <= row_n;
      col    <= col_n;
      top    <= top_n;
      cnt    <= cnt_n;
    end
  end

  // --------------------------------------------------------------------------
  // Character RAM: one write port, one registered read port
  // --------------------------------------------------------------------------
  logic [7:0]    mem [CELLS];
  logic [7:0]    rd_data;
  logic [AW-1:0] raddr;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

  // --------------------------------------------------------------------------
  // Redraw engine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    R_IDLE,
    R_HOME,
    R_ROW,
    R_EOL
`ifdef TERMBUF_CURSOR_EN
    , R_CUR
`endif
  } rstate_t;

  rstate_t          rstate, rstate_n;
  logic [2:0]       ridx, ridx_n;
  logic [ROW_W-1:0] rrow, rrow_n;
  logic [COL_W-1:0] rcol, rcol_n;
  logic [1:0]       gap;
  logic             pending, start, adv;
  logic [7:0]       tx_sel;
`ifdef TERMBUF_CURSOR_EN
  logic [6:0]       cur_r, cur_c;
  logic [2:0]       cur_next;

  // Tens digits are omitted for single-digit values.
  always_comb begin
    cur_next = ridx + 3'd1;
    if (cur_next == 3'd2 && cur_r < 7'd10) cur_next = 3'd3;
    if (cur_next == 3'd5 && cur_c < 7'd10) cur_next = 3'd6;
  end
`endif

  assign adv    = o_byte_v && i_tx_done;
  assign o_busy = (rstate != R_IDLE);
  assign raddr  = cell_addr(phys_row(rrow, top), rcol);

  always_comb begin
    rstate_n = rstate;
    ridx_n   = ridx;
    rrow_n   = rrow;
    rcol_n   = rcol;
    start    = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (req || pending) begin
          rstate_n = R_HOME;
          ridx_n   = '0;
          start    = 1'b1;
        end
      end
      R_HOME: begin
        if (adv) begin
          if (ridx == 3'd2) begin
            rstate_n = R_ROW;
            rrow_n   = '0;
            rcol_n   = '0;
          end else begin
            ridx_n = ridx + 3'd1;
          end
        end
      end
      R_ROW: begin
        if (adv) begin
          if (rcol != COL_LAST) begin
            rcol_n = rcol + COL_W'(1);
          end else if (rrow != ROW_LAST) begin
            rstate_n = R_EOL;
            ridx_n   = '0;
          end else begin
`ifdef TERMBUF_CURSOR_EN
            rstate_n = R_CUR;
            ridx_n   = '0;
`else
            rstate_n = R_IDLE;
`endif
          end
        end
      end
      R_EOL: begin
        if (adv) begin
          if (ridx == 3'd1) begin
            rstate_n = R_ROW;
            rrow_n   = rrow + ROW_W'(1);
            rcol_n   = '0;
          end else begin
            ridx_n = 3'd1;
          end
        end
      end
`ifdef TERMBUF_CURSOR_EN
      R_CUR: begin
        if (adv) begin
          if (ridx == 3'd7) rstate_n = R_IDLE;
          else              ridx_n   = cur_next;
        end
      end
`endif
      default: rstate_n = R_IDLE;
    endcase
  end

  always_comb begin
    tx_sel = rd_data;
    case (rstate)
      R_HOME: tx_sel = (ridx == 3'd0) ? 8'h1B : (ridx == 3'd1) ? 8'h5B : 8'h48;
      R_EOL:  tx_sel = (ridx == 3'd0) ? 8'h0D : 8'h0A;
`ifdef TERMBUF_CURSOR_EN
      R_CUR: begin
        case (ridx)
          3'd0:    tx_sel = 8'h1B;
          3'd1:    tx_sel = 8'h5B;
          3'd2:    tx_sel = 8'h30 + {1'b0, cur_r / 7'd10};
          3'd3:    tx_sel = 8'h30 + {1'b0, cur_r % 7'd10};
          3'd4:    tx_sel = 8'h3B;
          3'd5:    tx_sel = 8'h30 + {1'b0, cur_c / 7'd10};
          3'd6:    tx_sel = 8'h30 + {1'b0, cur_c % 7'd10};
          default: tx_sel = 8'h48;
        endcase
      end
`endif
      default: tx_sel = rd_data;
    endcase
  end

  // gap counts the two cycles needed for the RAM read of the next byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate   <= R_IDLE;
      ridx     <= '0;
      rrow     <= '0;
      rcol     <= '0;
      pending  <= 1'b0;
      gap      <= 2'd0;
      o_byte   <= 8'h00;
      o_byte_v <= 1'b0;
`ifdef TERMBUF_CURSOR_EN
      cur_r    <= 7'd1;
      cur_c    <= 7'd1;
`endif
    end else begin
      rstate <= rstate_n;
      ridx   <= ridx_n;
      rrow   <= rrow_n;
      rcol   <= rcol_n;
      if (start)    pending <= 1'b0;
      else if (req) pending <= 1'b1;
      if (start) begin
        gap <= 2'd2;
      end else if (adv) begin
        o_byte_v <= 1'b0;
        gap      <= (rstate_n != R_IDLE) ? 2'd2 : 2'd0;
      end else if (gap == 2'd2) begin
        gap <= 2'd1;
      end else if (gap == 2'd1) begin
        o_byte   <= tx_sel;
        o_byte_v <= 1'b1;
        gap      <= 2'd0;
      end
`ifdef TERMBUF_CURSOR_EN
      if (rstate == R_ROW && rstate_n == R_CUR) begin
        cur_r <= 7'(row) + 7'd1;
        cur_c <= 7'(col) + 7'd1;
      end
`endif
    end
  end

endmodule
`default_nettype wire
